// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-stage program-counter sequencer with stall, redirect, trap/EPC capture and halt FSM.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_seq_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             fetch_ready,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc,
    input  logic             stall,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap,
    output logic [WIDTH-1:0] epc,
    output logic             misalign,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted
`ifdef PC_RAS_EN
    ,
    input  logic             ras_push,
    input  logic             ras_pop,
    output logic             ras_empty
`endif
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INC);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // INC must be a non-zero power of two; the stack needs at least one entry
    if (INC == 0 || (INC & (INC - 1)) != 0 || RAS_DEPTH == 0) begin : g_bad_param
        $error("pc_seq_unit: illegal INC or RAS_DEPTH");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_d, epc_d;
    logic             misalign_d;
    logic             fire, target_bad;

    assign fire       = pc_valid & fetch_ready;
    assign target_bad = |(redirect_pc & ALIGN_MASK);

`ifdef PC_RAS_EN
    localparam int unsigned      PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(RAS_DEPTH - 1);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_top, ras_top_d, ras_wr_idx;
    logic [CNT_W-1:0] ras_cnt, ras_cnt_d;
    logic             ras_wr, ras_flush, pop_ok, push_ok;

    assign ras_flush = trap | (redirect_en & target_bad);
    assign pop_ok    = ras_pop & ~ras_empty & ~trap & ~redirect_en;
    assign push_ok   = ras_push & fire & ~stall & ~ras_flush;

    // Circular stack: a push when full silently overwrites the oldest entry
    always_comb begin
        ras_top_d  = ras_top;
        ras_cnt_d  = ras_cnt;
        ras_wr     = 1'b0;
        ras_wr_idx = ras_top;
        if (ras_flush) begin
            ras_cnt_d = '0;
        end else if (pop_ok && push_ok) begin
            ras_wr = 1'b1;
        end else if (pop_ok) begin
            ras_top_d = (ras_top == '0) ? LAST : ras_top - PTR_W'(1);
            ras_cnt_d = ras_cnt - CNT_W'(1);
        end else if (push_ok) begin
            ras_top_d  = (ras_top == LAST) ? '0 : ras_top + PTR_W'(1);
            ras_wr_idx = ras_top_d;
            ras_wr     = 1'b1;
            if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ras_top   <= '0;
            ras_cnt   <= '0;
            ras_empty <= 1'b1;
        end else begin
            ras_top   <= ras_top_d;
            ras_cnt   <= ras_cnt_d;
            ras_empty <= (ras_cnt_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (ras_wr) begin
            ras_mem[ras_wr_idx] <= pc + STEP;
        end
    end
`endif

    // Next-state and next-PC selection, highest priority first
    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        epc_d      = epc;
        misalign_d = misalign;

        case (state_q)
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume)   state_d = RUN;
            default: state_d = RUN;
        endcase

        if (trap) begin
            epc_d = pc;
            pc_d  = TRAP_VECTOR;
        end else if (redirect_en && target_bad) begin
            epc_d      = redirect_pc;
            pc_d       = TRAP_VECTOR;
            misalign_d = 1'b1;
        end else if (redirect_en) begin
            pc_d       = redirect_pc;
            misalign_d = 1'b0;
`ifdef PC_RAS_EN
        end else if (pop_ok) begin
            pc_d = ras_mem[ras_top];
`endif
        end else if (halt_req && state_q == RUN) begin
            pc_d = pc;
        end else if (fire && !stall) begin
            pc_d = pc + STEP;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= RUN;
            pc       <= RESET_VECTOR;
            epc      <= '0;
            misalign <= 1'b0;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            epc      <= epc_d;
            misalign <= misalign_d;
            pc_valid <= (state_d == RUN);
            halted   <= (state_d == HALT);
        end
    end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Testbench for pc_seq_unit (default build): directed scenarios followed by random traffic
// checked against a cycle-level behavioural model of the sequencer.
module tb_pc_seq_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] epc;
    logic        misalign;
    logic        halt_req;
    logic        resume;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_pc, m_epc;
    bit          m_mis, m_halted;

    pc_seq_unit dut (
        .CLK         (CLK),
        .reset       (reset),
        .fetch_ready (fetch_ready),
        .pc_valid    (pc_valid),
        .pc          (pc),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .trap        (trap),
        .epc         (epc),
        .misalign    (misalign),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the sequencer described directly from its priority rules
    task automatic model_step(input bit rst, rdy, stl, rde, input logic [31:0] rpc,
                              input bit trp, hreq, res);
        bit was_halted;
        bit do_fire;
        was_halted = m_halted;
        do_fire    = !was_halted && rdy;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_mis = 0; m_halted = 0;
            return;
        end
        if (trp) begin
            m_epc = m_pc;
            m_pc  = 32'h80;
        end else if (rde) begin
            if (rpc % 4 != 0) begin
                m_epc = rpc; m_pc = 32'h80; m_mis = 1;
            end else begin
                m_pc = rpc; m_mis = 0;
            end
        end else if (hreq && !was_halted) begin
            m_pc = m_pc;
        end else if (!stl && do_fire) begin
            m_pc = m_pc + 32'd4;
        end
        if (!was_halted && hreq)     m_halted = 1;
        else if (was_halted && res)  m_halted = 0;
    endtask

    task automatic cyc(input bit rst, rdy, stl, rde, input logic [31:0] rpc,
                       input bit trp, hreq, res);
        @(negedge CLK);
        reset = rst; fetch_ready = rdy; stall = stl; redirect_en = rde;
        redirect_pc = rpc; trap = trp; halt_req = hreq; resume = res;
        model_step(rst, rdy, stl, rde, rpc, trp, hreq, res);
        @(posedge CLK);
        #1;
        chk("pc",       pc,               m_pc);
        chk("epc",      epc,              m_epc);
        chk("misalign", 32'(misalign),    32'(m_mis));
        chk("halted",   32'(halted),      32'(m_halted));
        chk("pc_valid", 32'(pc_valid),    32'(!m_halted));
    endtask

    initial begin
        reset = 1; fetch_ready = 0; stall = 0; redirect_en = 0;
        redirect_pc = '0; trap = 0; halt_req = 0; resume = 0;

        // reset state
        cyc(1, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(pc_valid), 32'h1);

        // sequential fetch
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 0, 32'h0, 0, 0, 0);
            chk("seq_pc", pc, 32'(4 * i));
        end

        // not ready / stalled holds pc
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 32'h0, 0, 0, 0);
        chk("hold_notready", pc, 32'hC);
        cyc(0, 1, 1, 0, 32'h0, 0, 0, 0);
        chk("hold_stall", pc, 32'hC);
        cyc(0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("resume_inc", pc, 32'h10);

        // redirects
        cyc(0, 1, 1, 1, 32'h200, 0, 0, 0);
        chk("redir_stall", pc, 32'h200);
        cyc(0, 1, 0, 1, 32'h202, 0, 0, 0);
        chk("misal_pc", pc, 32'h80);
        chk("misal_epc", epc, 32'h202);
        chk("misal_flag", 32'(misalign), 32'h1);
        cyc(0, 0, 0, 1, 32'h40, 0, 0, 0);
        chk("align_clear", 32'(misalign), 32'h0);

        // trap beats redirect
        cyc(0, 1, 0, 1, 32'h300, 1, 0, 0);
        chk("trap_pc", pc, 32'h80);
        chk("trap_epc", epc, 32'h40);

        // wrap-around
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // halt / resume
        cyc(0, 1, 0, 0, 32'h0, 0, 1, 0);
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_valid", 32'(pc_valid), 32'h0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("halt_frozen", pc, 32'h0);
        cyc(0, 1, 0, 1, 32'h100, 0, 0, 0);
        chk("halt_redir_pc", pc, 32'h100);
        chk("halt_redir_state", 32'(halted), 32'h1);
        cyc(0, 1, 0, 0, 32'h0, 0, 0, 1);
        chk("resume_flag", 32'(halted), 32'h0);
        cyc(0, 1, 0, 0, 32'h0, 0, 0, 0);
        chk("resume_fire", pc, 32'h104);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom % 4 != 0) rpc[1:0] = 2'b00;
            cyc(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
                ($urandom % 8) == 0, rpc, ($urandom % 16) == 0,
                ($urandom % 12) == 0, ($urandom % 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
